// File: rtl/conv2d_sequencer_pkg.sv
// conv_pkg: state encoding and sizing helpers for the
// time-multiplexed 2-D convolution sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE, BIAS, MAC, DRAIN, WRITE, DONE
  } state_t;

  function automatic int out_dim(
    input int size,
    input int k,
    input int pad,
    input int stride
  );
    return (size + 2 * pad - k) / stride + 1;
  endfunction

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int acc_w(input int dw, input int taps);
    return 2 * dw + $clog2(taps + 1);
  endfunction

  function automatic logic signed [63:0] sat(
    input logic signed [63:0] acc,
    input int dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/conv2d_sequencer_if.sv
// Result port of the convolution sequencer: addressed
// data with a valid/ready handshake.
interface conv2d_sequencer_if #(
  parameter int AW = 1,
  parameter int DW = 8
);
  logic                 valid;
  logic                 ready;
  logic [AW-1:0]        addr;
  logic signed [DW-1:0] data;

  modport master (
    output valid, addr, data,
    input  ready
  );

  modport slave (
    input  valid, addr, data,
    output ready
  );
endinterface

// File: rtl/conv2d_sequencer_mac.sv
// conv_mac: single multiply-accumulate lane with bias load,
// padded-pixel zeroing and saturating readout.
module conv_mac
  import conv_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic                 zero_pixel,
  input  logic signed [DW-1:0] pixel,
  input  logic signed [DW-1:0] weight,
  input  logic signed [DW-1:0] bias,
  output logic signed [DW-1:0] result
);

  logic signed [ACC_W-1:0] acc;
  logic signed [2*DW-1:0]  px;
  logic signed [2*DW-1:0]  wt;
  logic signed [2*DW-1:0]  prod;

  always_comb begin
    px   = (2 * DW)'(pixel);
    wt   = (2 * DW)'(weight);
    prod = zero_pixel ? '0 : px * wt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'(bias);
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  assign result = DW'(sat(64'(acc), DW));

endmodule

// File: rtl/conv2d_sequencer.sv
// conv2d_sequencer: FSM, loop counters and address generation
// driving one shared MAC across every output pixel and tap.
module conv2d_sequencer
  import conv_pkg::*;
#(
  parameter int in_channels  = 1,
  parameter int out_channels = 1,
  parameter int kernel_rows  = 3,
  parameter int kernel_cols  = 3,
  parameter int stride_row   = 1,
  parameter int stride_col   = 1,
  parameter int pad_rows     = 0,
  parameter int pad_cols     = 0,
  parameter int rows         = 27,
  parameter int cols         = 27,
  parameter int data_size    = 8,
  localparam int OR    = out_dim(rows, kernel_rows, pad_rows, stride_row),
  localparam int OC    = out_dim(cols, kernel_cols, pad_cols, stride_col),
  localparam int TAPS  = in_channels * kernel_rows * kernel_cols,
  localparam int IN_AW = cw(in_channels * rows * cols),
  localparam int K_AW  = cw(out_channels * TAPS),
  localparam int B_AW  = cw(out_channels),
  localparam int O_AW  = cw(out_channels * OR * OC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        in_rd_en,
  output logic [IN_AW-1:0]            in_rd_addr,
  input  logic signed [data_size-1:0] in_rd_data,
  output logic [K_AW-1:0]             kern_rd_addr,
  input  logic signed [data_size-1:0] kern_rd_data,
  output logic [B_AW-1:0]             bias_rd_addr,
  input  logic signed [data_size-1:0] bias_rd_data,
  conv2d_sequencer_if.master          out
);

  localparam int ACC_W = acc_w(data_size, TAPS);
  localparam int CI_W  = cw(in_channels);
  localparam int KR_W  = cw(kernel_rows);
  localparam int KC_W  = cw(kernel_cols);
  localparam int OR_W  = cw(OR);
  localparam int OC_W  = cw(OC);

  localparam logic [CI_W-1:0] CI_LAST = CI_W'(in_channels - 1);
  localparam logic [KR_W-1:0] KR_LAST = KR_W'(kernel_rows - 1);
  localparam logic [KC_W-1:0] KC_LAST = KC_W'(kernel_cols - 1);
  localparam logic [B_AW-1:0] CO_LAST = B_AW'(out_channels - 1);
  localparam logic [OR_W-1:0] OR_LAST = OR_W'(OR - 1);
  localparam logic [OC_W-1:0] OC_LAST = OC_W'(OC - 1);

  state_t state;

  logic [CI_W-1:0] ci, nci;
  logic [KR_W-1:0] kr, nkr;
  logic [KC_W-1:0] kc, nkc;
  logic [B_AW-1:0] co;
  logic [OR_W-1:0] orow;
  logic [OC_W-1:0] ocol;

  logic mac_load, mac_en, zero_q;
  logic pad, last_tap, last_out, issue;
  int   r, c, ia, ka, oa;

  logic signed [data_size-1:0] sat_res;

  assign bias_rd_addr = co;
  assign out.data     = sat_res;

  // Next tap to issue: restart at tap 0 from BIAS, else step kc, kr, ci.
  always_comb begin
    nci = '0;
    nkr = '0;
    nkc = '0;
    if (state == MAC) begin
      nci = ci;
      nkr = kr;
      nkc = kc + 1'b1;
      if (kc == KC_LAST) begin
        nkc = '0;
        nkr = kr + 1'b1;
        if (kr == KR_LAST) begin
          nkr = '0;
          nci = ci + 1'b1;
        end
      end
    end
    r   = int'(orow) * stride_row + int'(nkr) - pad_rows;
    c   = int'(ocol) * stride_col + int'(nkc) - pad_cols;
    pad = (r < 0) || (r >= rows) || (c < 0) || (c >= cols);
    ia  = (int'(nci) * rows + r) * cols + c;
    ka  = int'(co) * in_channels + int'(nci);
    ka  = (ka * kernel_rows + int'(nkr)) * kernel_cols + int'(nkc);
    oa  = (int'(co) * OR + int'(orow)) * OC + int'(ocol);
    last_tap = (ci == CI_LAST) && (kr == KR_LAST) && (kc == KC_LAST);
    last_out = (co == CO_LAST) && (orow == OR_LAST) && (ocol == OC_LAST);
    issue    = (state == BIAS) || ((state == MAC) && !last_tap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ci           <= '0;
      kr           <= '0;
      kc           <= '0;
      co           <= '0;
      orow         <= '0;
      ocol         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      in_rd_en     <= 1'b0;
      in_rd_addr   <= '0;
      kern_rd_addr <= '0;
      out.valid    <= 1'b0;
      out.addr     <= '0;
      mac_load     <= 1'b0;
      mac_en       <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      done     <= 1'b0;
      mac_load <= (state == BIAS);
      mac_en   <= (state == MAC);
      zero_q   <= ~in_rd_en;
      in_rd_en <= 1'b0;
      if (issue) begin
        ci           <= nci;
        kr           <= nkr;
        kc           <= nkc;
        in_rd_en     <= ~pad;
        in_rd_addr   <= pad ? '0 : IN_AW'(ia);
        kern_rd_addr <= K_AW'(ka);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= BIAS;
            busy  <= 1'b1;
          end
        end
        BIAS: state <= MAC;
        MAC: begin
          if (last_tap) state <= DRAIN;
        end
        DRAIN: begin
          state     <= WRITE;
          out.valid <= 1'b1;
          out.addr  <= O_AW'(oa);
        end
        WRITE: begin
          if (out.ready) begin
            out.valid <= 1'b0;
            if (last_out) begin
              state <= DONE;
              done  <= 1'b1;
              co    <= '0;
              orow  <= '0;
              ocol  <= '0;
            end else begin
              state <= BIAS;
              ocol  <= ocol + 1'b1;
              if (ocol == OC_LAST) begin
                ocol <= '0;
                orow <= orow + 1'b1;
                if (orow == OR_LAST) begin
                  orow <= '0;
                  co   <= co + 1'b1;
                end
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  conv_mac #(
    .DW    (data_size),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .load       (mac_load),
    .en         (mac_en),
    .zero_pixel (zero_q),
    .pixel      (in_rd_data),
    .weight     (kern_rd_data),
    .bias       (bias_rd_data),
    .result     (sat_res)
  );

endmodule

// File: tb/tb_conv2d_sequencer.sv
// Scoreboard bench for conv2d_sequencer: random feature maps and
// kernels checked against a direct loop-nest convolution model.
module tb_conv2d_sequencer;

  localparam int IC   = 2;
  localparam int OCH  = 2;
  localparam int KR   = 3;
  localparam int KC   = 2;
  localparam int SR   = 2;
  localparam int SC   = 1;
  localparam int PR   = 1;
  localparam int PC   = 1;
  localparam int ROWS = 5;
  localparam int COLS = 4;
  localparam int DW   = 8;

  localparam int ORR   = (ROWS + 2 * PR - KR) / SR + 1;
  localparam int OCC   = (COLS + 2 * PC - KC) / SC + 1;
  localparam int TAPS  = IC * KR * KC;
  localparam int NOUT  = OCH * ORR * OCC;
  localparam int NIN   = IC * ROWS * COLS;
  localparam int NK    = OCH * TAPS;
  localparam int IN_AW = $clog2(NIN);
  localparam int K_AW  = $clog2(NK);
  localparam int B_AW  = 1;
  localparam int O_AW  = $clog2(NOUT);
  localparam int LIMIT = NOUT * (TAPS + 3) * 4 + 100;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic clk, rst, start, busy, done, in_rd_en;
  logic [IN_AW-1:0]     in_rd_addr;
  logic signed [DW-1:0] in_rd_data;
  logic [K_AW-1:0]      kern_rd_addr;
  logic signed [DW-1:0] kern_rd_data;
  logic [B_AW-1:0]      bias_rd_addr;
  logic signed [DW-1:0] bias_rd_data;

  conv2d_sequencer_if #(.AW(O_AW), .DW(DW)) oif ();

  conv2d_sequencer #(
    .in_channels  (IC),
    .out_channels (OCH),
    .kernel_rows  (KR),
    .kernel_cols  (KC),
    .stride_row   (SR),
    .stride_col   (SC),
    .pad_rows     (PR),
    .pad_cols     (PC),
    .rows         (ROWS),
    .cols         (COLS),
    .data_size    (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .in_rd_en     (in_rd_en),
    .in_rd_addr   (in_rd_addr),
    .in_rd_data   (in_rd_data),
    .kern_rd_addr (kern_rd_addr),
    .kern_rd_data (kern_rd_data),
    .bias_rd_addr (bias_rd_addr),
    .bias_rd_data (bias_rd_data),
    .out          (oif)
  );

  logic signed [DW-1:0] in_mem   [NIN];
  logic signed [DW-1:0] kern_mem [NK];
  logic signed [DW-1:0] bias_mem [OCH];

  exp_t q[$];
  int   n_checks, n_fail;
  int   rmode, hold, first_len, rd_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Synchronous memories; a disabled input read returns junk.
  always @(posedge clk) begin
    if (in_rd_en && int'(in_rd_addr) < NIN)
      in_rd_data <= in_mem[in_rd_addr];
    else
      in_rd_data <= DW'($urandom);
    if (int'(kern_rd_addr) < NK)
      kern_rd_data <= kern_mem[kern_rd_addr];
    else
      kern_rd_data <= DW'($urandom);
    bias_rd_data <= bias_mem[bias_rd_addr];
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Downstream ready: 0 always, 1 random, 2 stall first result 5 cycles.
  initial begin
    oif.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: oif.ready = 1'($urandom_range(0, 1));
        2: begin
          if (oif.valid && hold < 5) begin
            oif.ready = 1'b0;
            hold++;
          end else begin
            oif.ready = 1'b1;
          end
        end
        default: oif.ready = 1'b1;
      endcase
    end
  end

  // Output monitor: scoreboard pop plus hold-while-stalled checks.
  initial begin
    logic pv, pr;
    int   pd, pa, vlen;
    exp_t e;
    pv = 1'b0; pr = 1'b0; pd = 0; pa = 0; vlen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        vlen = 0;
      end else begin
        if (in_rd_en) rd_cnt++;
        if (pv && !pr) begin
          check("hold_valid", int'(oif.valid), 1);
          check("hold_data", int'(oif.data), pd);
          check("hold_addr", int'(oif.addr), pa);
        end
        if (oif.valid) vlen++;
        if (oif.valid && oif.ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: addr %0d data %0d, expected none",
                     oif.addr, oif.data);
          end else begin
            e = q.pop_front();
            check("out_addr", int'(oif.addr), e.addr);
            check("out_data", int'(oif.data), e.data);
          end
          if (first_len < 0) first_len = vlen;
          vlen = 0;
        end
        pv = oif.valid;
        pr = oif.ready;
        pd = int'(oif.data);
        pa = int'(oif.addr);
      end
    end
  end

  function automatic int ref_out(
    input int co, input int orow, input int ocol, output int nread
  );
    int acc, r, c, p;
    acc = int'(bias_mem[co]);
    nread = 0;
    for (int ci = 0; ci < IC; ci++)
      for (int kr = 0; kr < KR; kr++)
        for (int kc = 0; kc < KC; kc++) begin
          r = orow * SR + kr - PR;
          c = ocol * SC + kc - PC;
          if (r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
            p = int'(in_mem[(ci * ROWS + r) * COLS + c]) *
                int'(kern_mem[((co * IC + ci) * KR + kr) * KC + kc]);
            acc += p;
            nread++;
          end
        end
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return acc;
  endfunction

  task automatic fill(input int kind);
    for (int i = 0; i < NIN; i++)
      case (kind)
        0: in_mem[i] = DW'($urandom);
        1: in_mem[i] = DW'($urandom_range(0, 6) - 3);
        2: in_mem[i] = 8'sd1;
        default: in_mem[i] = 8'sd127;
      endcase
    for (int i = 0; i < NK; i++)
      case (kind)
        0: kern_mem[i] = DW'($urandom);
        1: kern_mem[i] = DW'($urandom_range(0, 6) - 3);
        2: kern_mem[i] = 8'sd1;
        3: kern_mem[i] = 8'sd127;
        default: kern_mem[i] = -8'sd128;
      endcase
    for (int i = 0; i < OCH; i++)
      case (kind)
        0: bias_mem[i] = DW'($urandom);
        1: bias_mem[i] = DW'($urandom_range(0, 40) - 20);
        default: bias_mem[i] = 8'sd0;
      endcase
  endtask

  task automatic run(input int mode, input bit chk_time, input bit mid);
    exp_t e;
    int   nrd, exp_rd, cyc;
    exp_rd = 0;
    for (int co = 0; co < OCH; co++)
      for (int orow = 0; orow < ORR; orow++)
        for (int ocol = 0; ocol < OCC; ocol++) begin
          e.addr = (co * ORR + orow) * OCC + ocol;
          e.data = ref_out(co, orow, ocol, nrd);
          exp_rd += nrd;
          q.push_back(e);
        end
    rmode = mode;
    hold = 0;
    first_len = -1;
    rd_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 20) check("busy_mid_run", int'(busy), 1);
      if (mid && cyc == 40) start = 1'b1;
      if (mid && cyc == 41) start = 1'b0;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done after %0d cycles", cyc);
    end else if (chk_time) begin
      check("done_cycles", cyc, NOUT * (TAPS + 3) + 1);
    end
    if (mid) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("pending_outputs", q.size(), 0);
    check("input_reads", rd_cnt, exp_rd);
    if (mode == 2) check("stall_valid_cycles", first_len, 6);
    q.delete();
  endtask

  task automatic abort_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_valid", int'(oif.valid), 0);
    check("abort_rd_en", int'(in_rd_en), 0);
    repeat (30) @(negedge clk);
    check("abort_stays_idle", int'(busy), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rmode = 0;
    hold = 0;
    first_len = -1;
    rd_cnt = 0;
    rst = 1'b1;
    start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_rd_en", int'(in_rd_en), 0);
    check("rst_out_valid", int'(oif.valid), 0);
    check("rst_out_data", int'(oif.data), 0);
    check("rst_out_addr", int'(oif.addr), 0);
    check("rst_in_addr", int'(in_rd_addr), 0);
    check("rst_kern_addr", int'(kern_rd_addr), 0);
    check("rst_bias_addr", int'(bias_rd_addr), 0);
    rst = 1'b0;

    run(0, 1'b1, 1'b0);
    fill(1);
    run(1, 1'b0, 1'b0);
    fill(2);
    run(0, 1'b1, 1'b1);
    fill(3);
    run(0, 1'b1, 1'b0);
    fill(4);
    run(0, 1'b1, 1'b0);
    fill(1);
    run(2, 1'b0, 1'b0);
    abort_run();
    run(0, 1'b1, 1'b0);
    fill(0);
    run(1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
